// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit.
// One result bit per cycle; start/busy/done handshake; fixed latency of
// XLEN+2 cycles from the accepting edge to the done pulse.
// Build option MULDIV_DIV_EN: when defined, the restoring divider is compiled in.
// When undefined, divide/remainder requests complete at once with illegal=1.
//
// Handshake: a request is accepted on a rising edge where start=1, busy=0,
// flush=0 and the ALUOp/Funct7 pair selects the M extension. Operands are
// sampled only at that edge. busy is high from the following cycle until the
// result is written. done pulses for exactly one cycle with result (and
// illegal) valid. A new request may be accepted in the done cycle.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            flush,
   input  logic [1:0]      ALUOp,
   input  logic [6:0]      Funct7,
   input  logic [2:0]      Funct3,
   input  logic [XLEN-1:0] srcA,
   input  logic [XLEN-1:0] srcB,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            illegal
);

   localparam int CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [2:0]          op;
   logic                sign_a;
   logic                sign_b;
   // Multiply: {product high, multiplier/product low}.
   // Divide:   {partial remainder, dividend/quotient}.
   logic [2*XLEN-1:0]   acc;
   // Multiplicand magnitude for multiply, divisor magnitude for divide.
   logic [XLEN-1:0]     opnd;
`ifdef MULDIV_DIV_EN
   // Raw operands are kept for the divide-by-zero and overflow overrides.
   logic [XLEN-1:0]     a_raw;
   logic [XLEN-1:0]     b_raw;
   logic [XLEN:0]       rem_sh;
   logic [XLEN:0]       diff;
   logic [XLEN-1:0]     q_fix;
   logic [XLEN-1:0]     r_fix;
   logic                div_zero;
   logic                div_ovf;
`endif

   logic                is_m;
   logic                accept;
   logic                a_signed;
   logic                b_signed;
   logic                in_sign_a;
   logic                in_sign_b;
   logic [XLEN-1:0]     mag_a;
   logic [XLEN-1:0]     mag_b;
   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   acc_next;
   logic [2*XLEN-1:0]   prod_signed;
   logic [XLEN-1:0]     div_val;
   logic [XLEN-1:0]     fix_val;

   // Request decode, operand signedness and magnitude conversion.
   always_comb begin
      is_m      = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
      accept    = start && !busy && is_m && !flush;
      a_signed  = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                  (Funct3 == 3'b100) || (Funct3 == 3'b110);
      // MULHSU treats rs2 as unsigned, so only MULH/DIV/REM sign rs2.
      b_signed  = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
      in_sign_a = a_signed && srcA[XLEN-1];
      in_sign_b = b_signed && srcB[XLEN-1];
      mag_a     = in_sign_a ? -srcA : srcA;
      mag_b     = in_sign_b ? -srcB : srcB;
   end

   // One iteration step: shift-add for multiply, restoring step for divide.
   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + ({1'b0, opnd} & {(XLEN+1){acc[0]}});
      acc_next = {mul_sum, acc[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
      rem_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      diff   = rem_sh - {1'b0, opnd};
      if (op[2]) begin
         if (diff[XLEN])
            acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
         else
            acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end
`endif
   end

   // Sign correction and special-case selection for the final result.
   always_comb begin
      prod_signed = (sign_a ^ sign_b) ? -acc : acc;
      div_val     = '0;
`ifdef MULDIV_DIV_EN
      q_fix    = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      r_fix    = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      div_zero = (b_raw == '0);
      div_ovf  = !op[0] && (a_raw == {1'b1, {(XLEN-1){1'b0}}}) && (b_raw == '1);
      if (div_zero) begin
         q_fix = '1;
         r_fix = a_raw;
      end else if (div_ovf) begin
         q_fix = a_raw;
         r_fix = '0;
      end
      div_val = op[1] ? r_fix : q_fix;
`endif
      fix_val = '0;
      case (op)
         3'b000:                 fix_val = acc[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fix_val = prod_signed[2*XLEN-1:XLEN];
         default:                fix_val = div_val;
      endcase
   end

   // Control FSM with registered busy/done/illegal and the iteration datapath.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         op      <= '0;
         sign_a  <= 1'b0;
         sign_b  <= 1'b0;
         acc     <= '0;
         opnd    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         illegal <= 1'b0;
         result  <= '0;
`ifdef MULDIV_DIV_EN
         a_raw   <= '0;
         b_raw   <= '0;
`endif
      end else begin
         done    <= 1'b0;
         illegal <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               state <= S_IDLE;
               if (accept) begin
                  op     <= Funct3;
                  sign_a <= in_sign_a;
                  sign_b <= in_sign_b;
                  cnt    <= '0;
`ifdef MULDIV_DIV_EN
                  a_raw  <= srcA;
                  b_raw  <= srcB;
`endif
                  if (Funct3[2]) begin
                     acc  <= {{XLEN{1'b0}}, mag_a};
                     opnd <= mag_b;
                  end else begin
                     acc  <= {{XLEN{1'b0}}, mag_b};
                     opnd <= mag_a;
                  end
`ifdef MULDIV_DIV_EN
                  state <= S_CALC;
                  busy  <= 1'b1;
`else
                  // Without the divider, divide/remainder requests finish at once.
                  if (Funct3[2]) begin
                     state   <= S_DONE;
                     done    <= 1'b1;
                     illegal <= 1'b1;
                     result  <= '0;
                  end else begin
                     state <= S_CALC;
                     busy  <= 1'b1;
                  end
`endif
               end
            end
            S_CALC: begin
               if (flush) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  acc <= acc_next;
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_W'(XLEN - 1)) begin
                     state <= S_FIX;
                     cnt   <= '0;
                  end
               end
            end
            S_FIX: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               if (!flush) begin
                  state  <= S_DONE;
                  done   <= 1'b1;
                  result <= fix_val;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M/RV64M multiply/divide execution unit, parametrised in operand width, that extends the execute stage's ALU-control decode with the M-extension encodings (ALUOp = 2'b10, Funct7 = 7'b0000001). It accepts one operation at a time over a start/busy/done handshake. It computes one result bit per cycle and holds the pipeline through `busy` until the registered result is presented with a one-cycle `done` pulse.

## Interface
- `XLEN`, 32: operand and result width. Legal values are 32 and 64.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only when `busy`=0
- `flush`  in  1  synchronous abort of the operation in flight; no `done` follows
- `ALUOp`  in  2  ALU opcode class from the Controller
- `Funct7`  in  7  instruction bits 31:25
- `Funct3`  in  3  instruction bits 14:12
- `srcA`  in  XLEN  rs1 value (dividend / multiplicand)
- `srcB`  in  XLEN  rs2 value (divisor / multiplier)
- `busy`  out  1  unit occupied; stall the pipeline
- `done`  out  1  one-cycle pulse; `result` is valid
- `result`  out  XLEN  registered result; holds its value until the next `done`
- `illegal`  out  1  qualifies `done`; set when the operation is not supported in this build

## Operation
- Accept condition: `start` && !`busy` && `ALUOp`==2'b10 && `Funct7`==7'b0000001. A start that does not meet this condition is ignored, and no `done` follows it.
- On accept, the unit latches `srcA`, `srcB` and `Funct3`.
- Funct3 decode:
  - 000 MUL (low XLEN bits)
  - 001 MULH (signed×signed, high XLEN bits)
  - 010 MULHSU (signed×unsigned, high)
  - 011 MULHU (unsigned×unsigned, high)
  - 100 DIV
  - 101 DIVU
  - 110 REM
  - 111 REMU
- Datapath:
  - Operands are converted to magnitudes according to their signedness.
  - Multiply is an unsigned shift-add into a 2·XLEN accumulator, one multiplier bit per cycle.
  - Divide is unsigned restoring division, one quotient bit per cycle, with an XLEN-bit remainder.
- Sign fix:
  - Product sign = signA ^ signB, where signB is forced to 0 for MULHSU and MULHU.
  - Quotient sign = signA ^ signB.
  - Remainder sign = signA.
  - A negative result is produced by two's-complement negation of the magnitude.
- Special cases (RISC-V defined). Both are resolved in FIX and do not shorten latency:
  - Divide by zero: quotient = all ones; remainder = `srcA`.
  - Signed overflow (−2^(XLEN−1) / −1): quotient = `srcA`; remainder = 0.
- State machine:
  - IDLE: `busy`=0. An accept moves to CALC.
  - CALC: `busy`=1. Iteration counter runs 0..XLEN−1; moves to FIX when the counter reaches XLEN−1.
  - FIX: `busy`=1. Sign correction and special-case selection; `result` is written; moves to DONE.
  - DONE: `busy`=0, `done`=1. Moves to IDLE, or to CALC if a new accept occurs in this same cycle (back-to-back operation).
- `flush` in CALC or FIX returns the unit to IDLE on the next edge. `result` is left unchanged and no `done` is issued. `flush` in IDLE or DONE has no effect.
- `flush` and `start` asserted in the same cycle: `flush` wins, and the start is not accepted.

## Timing
- Reset values:
  - state IDLE, counter 0
  - `busy`=0, `done`=0, `illegal`=0
  - `result`=0
- Reset asserted mid-operation aborts exactly like `flush`, and additionally clears `result`.
- Latency is fixed and independent of operand values:
  - Accepting edge is edge 0.
  - `busy` is high in cycles 1..XLEN+1.
  - `done` is high in cycle XLEN+2, i.e. 34 cycles for XLEN=32.
- `busy` never asserts combinationally from `start`. The pipeline stalls starting from the cycle after the accept, and the issuing stage keeps its operands stable only at the accept edge.
- `done` is never high for two consecutive cycles without a new accept in between.

## Configuration
- `MULDIV_DIV_EN` defined:
  - Divider datapath is compiled in; all eight operations execute as described.
  - `illegal` is always 0.
- `MULDIV_DIV_EN` undefined:
  - Divider logic is removed.
  - An accepted Funct3[2]=1 operation moves IDLE→DONE directly: `done`=1 in cycle 1, `result`=0, `illegal`=1.
  - Multiply behaviour is unchanged.

## Test plan
All scenarios use XLEN=32.
- MUL with `srcA`=7, `srcB`=0xFFFFFFFD → `result`=0xFFFFFFEB; `done` exactly 34 cycles after the start cycle; `busy` high in cycles 1..33.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Divide-by-zero and overflow cases:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
  - All at 34-cycle latency.
- Handshake and abort behaviour:
  - A start while `busy` is ignored.
  - `flush` in cycle 10 → `busy`=0 from cycle 11, no `done`, `result` unchanged.
  - A start in the DONE cycle is accepted, and its `done` follows 34 cycles later.
  - A start with `Funct7`=0 → no response.
- With `MULDIV_DIV_EN` undefined: DIV 10/2 → `done` in cycle 1 with `illegal`=1 and `result`=0; MUL 3×4 → 12 at 34 cycles.
